// File: rtl/multiport_register_file_if.sv
// Purpose: bundles the decode-side read/lock signals and writeback-side write signals of the register file.
// Ports:   read_register/read_data/read_busy (packed per port), write ports A and B, lock_valid/lock_register.
// Modports: master drives indices, writes and locks; slave is the register file itself.
interface multiport_register_file_if #(
  parameter int REGFILE_WIDTH = 3,
  parameter int DATA_WIDTH    = 4,
  parameter int READ_PORTS    = 2
);
  logic [READ_PORTS*REGFILE_WIDTH-1:0] read_register;
  logic [READ_PORTS*DATA_WIDTH-1:0]    read_data;
  logic [READ_PORTS-1:0]               read_busy;

  logic                     reg_write_a;
  logic [REGFILE_WIDTH-1:0] write_register_a;
  logic [DATA_WIDTH-1:0]    write_data_a;

  logic                     reg_write_b;
  logic [REGFILE_WIDTH-1:0] write_register_b;
  logic [DATA_WIDTH-1:0]    write_data_b;

  logic                     lock_valid;
  logic [REGFILE_WIDTH-1:0] lock_register;

  modport master (
    output read_register,
    output reg_write_a, write_register_a, write_data_a,
    output reg_write_b, write_register_b, write_data_b,
    output lock_valid, lock_register,
    input  read_data, read_busy
  );

  modport slave (
    input  read_register,
    input  reg_write_a, write_register_a, write_data_a,
    input  reg_write_b, write_register_b, write_data_b,
    input  lock_valid, lock_register,
    output read_data, read_busy
  );
endinterface

// File: rtl/multiport_register_file.sv
// Purpose: register file with N combinational read ports, two prioritised write ports (B over A),
//          optional write-to-read bypass, optional hardwired r0, and a per-register busy scoreboard.
// Latency: reads are combinational; writes/locks take effect at the next rising edge (bypass makes
//          writes and busy-clears visible in the same cycle). No back-pressure: every write/lock is accepted.
// Ports:   clock, reset_n (async, active-low), rf (slave modport of multiport_register_file_if).
module multiport_register_file #(
  parameter int REGFILE_WIDTH   = 3,
  parameter int DATA_WIDTH      = 4,
  parameter int REGFILE_R_WIDTH = 8,
  parameter int READ_PORTS      = 2,
  parameter int ZERO_REG        = 1,
  parameter int BYPASS          = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  multiport_register_file_if.slave rf
);

  logic [DATA_WIDTH-1:0]      regs [REGFILE_R_WIDTH];
  logic [REGFILE_R_WIDTH-1:0] busy;

  logic wr_a_en;
  logic wr_b_en;
  logic lock_en;

  // With a hardwired r0, anything addressed to index 0 is dropped here so
  // neither the storage, the scoreboard nor the bypass path ever sees it.
  assign wr_a_en = rf.reg_write_a && !((ZERO_REG != 0) && (rf.write_register_a == '0));
  assign wr_b_en = rf.reg_write_b && !((ZERO_REG != 0) && (rf.write_register_b == '0));
  assign lock_en = rf.lock_valid  && !((ZERO_REG != 0) && (rf.lock_register    == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REGFILE_R_WIDTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < REGFILE_R_WIDTH; i++) begin
        if (wr_b_en && (rf.write_register_b == REGFILE_WIDTH'(i))) begin
          regs[i] <= rf.write_data_b;
        end else if (wr_a_en && (rf.write_register_a == REGFILE_WIDTH'(i))) begin
          regs[i] <= rf.write_data_a;
        end
        // A lock in the same cycle as a write means a new producer was issued:
        // the bit must stay set.
        if (lock_en && (rf.lock_register == REGFILE_WIDTH'(i))) begin
          busy[i] <= 1'b1;
        end else if ((wr_a_en && (rf.write_register_a == REGFILE_WIDTH'(i))) ||
                     (wr_b_en && (rf.write_register_b == REGFILE_WIDTH'(i)))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [REGFILE_WIDTH-1:0] idx;
    logic                     hit_a;
    logic                     hit_b;
    logic                     hit_lock;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_busy;

    assign idx      = rf.read_register[p*REGFILE_WIDTH +: REGFILE_WIDTH];
    assign hit_a    = wr_a_en && (rf.write_register_a == idx);
    assign hit_b    = wr_b_en && (rf.write_register_b == idx);
    assign hit_lock = lock_en && (rf.lock_register    == idx);

    always_comb begin
      rd_data = regs[idx];
      rd_busy = busy[idx];
      if (BYPASS != 0) begin
        if (hit_b) begin
          rd_data = rf.write_data_b;
        end else if (hit_a) begin
          rd_data = rf.write_data_a;
        end
        // A same-index lock keeps the stored busy bit; the new lock itself
        // only becomes visible after the edge.
        if ((hit_a || hit_b) && !hit_lock) begin
          rd_busy = 1'b0;
        end
      end
      // Reset also masks the bypass path so nothing leaks out while held.
      if (((ZERO_REG != 0) && (idx == '0)) || !reset_n) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
    end

    assign rf.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    assign rf.read_busy[p]                          = rd_busy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  // if0: defaults (bypass on), if1: bypass off, if2: 4 ports x 8 bits x 16 regs
  multiport_register_file_if #(.REGFILE_WIDTH(3), .DATA_WIDTH(4), .READ_PORTS(2)) if0 ();
  multiport_register_file_if #(.REGFILE_WIDTH(3), .DATA_WIDTH(4), .READ_PORTS(2)) if1 ();
  multiport_register_file_if #(.REGFILE_WIDTH(4), .DATA_WIDTH(8), .READ_PORTS(4)) if2 ();

  multiport_register_file #(
    .REGFILE_WIDTH(3), .DATA_WIDTH(4), .REGFILE_R_WIDTH(8), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut0 (.clock(clock), .reset_n(reset_n), .rf(if0));

  multiport_register_file #(
    .REGFILE_WIDTH(3), .DATA_WIDTH(4), .REGFILE_R_WIDTH(8), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(0)
  ) u_dut1 (.clock(clock), .reset_n(reset_n), .rf(if1));

  multiport_register_file #(
    .REGFILE_WIDTH(4), .DATA_WIDTH(8), .REGFILE_R_WIDTH(16), .READ_PORTS(4), .ZERO_REG(1), .BYPASS(1)
  ) u_dut2 (.clock(clock), .reset_n(reset_n), .rf(if2));

  task automatic idle_all();
    if0.reg_write_a = 1'b0; if0.write_register_a = '0; if0.write_data_a = '0;
    if0.reg_write_b = 1'b0; if0.write_register_b = '0; if0.write_data_b = '0;
    if0.lock_valid  = 1'b0; if0.lock_register    = '0;
    if1.reg_write_a = 1'b0; if1.write_register_a = '0; if1.write_data_a = '0;
    if1.reg_write_b = 1'b0; if1.write_register_b = '0; if1.write_data_b = '0;
    if1.lock_valid  = 1'b0; if1.lock_register    = '0;
    if2.reg_write_a = 1'b0; if2.write_register_a = '0; if2.write_data_a = '0;
    if2.reg_write_b = 1'b0; if2.write_register_b = '0; if2.write_data_b = '0;
    if2.lock_valid  = 1'b0; if2.lock_register    = '0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (if0.read_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", if0.read_data); end
    n_cmp++; if (if0.read_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", if0.read_busy); end
    n_cmp++; if (if2.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_data_wide: got %h want 0", if2.read_data); end
    @(negedge clock); reset_n = 1'b1;
    // write r3=A and lock r4
    @(negedge clock);
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd3; if0.write_data_a = 4'hA;
    if0.lock_valid = 1'b1; if0.lock_register = 3'd4;
    @(negedge clock);
    idle_all();
    if0.read_register = {3'd4, 3'd3};
    #1;
    n_cmp++; if (if0.read_data[3:0] !== 4'hA) begin n_fail++; $display("FAIL pre_reset_r3: got %h want a", if0.read_data[3:0]); end
    n_cmp++; if (if0.read_busy[1] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy_r4: got %b want 1", if0.read_busy[1]); end
    // asynchronous reset between edges, with a write in flight
    #1; reset_n = 1'b0;
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd3; if0.write_data_a = 4'h5;
    #1;
    n_cmp++; if (if0.read_data !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %h want 00", if0.read_data); end
    n_cmp++; if (if0.read_busy !== 2'b00) begin n_fail++; $display("FAIL async_reset_busy: got %b want 00", if0.read_busy); end
    if0.reg_write_a = 1'b0;
    #1; reset_n = 1'b1;
    @(negedge clock); #1;
    n_cmp++; if (if0.read_data !== 8'h00) begin n_fail++; $display("FAIL post_reset_data: got %h want 00", if0.read_data); end
    n_cmp++; if (if0.read_busy !== 2'b00) begin n_fail++; $display("FAIL post_reset_busy: got %b want 00", if0.read_busy); end
  endtask

  task automatic test_dual_write();
    @(negedge clock);
    if0.read_register = {3'd0, 3'd5}; if1.read_register = {3'd0, 3'd5};
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd5; if0.write_data_a = 4'h3;
    if0.reg_write_b = 1'b1; if0.write_register_b = 3'd5; if0.write_data_b = 4'hC;
    if1.reg_write_a = 1'b1; if1.write_register_a = 3'd5; if1.write_data_a = 4'h3;
    if1.reg_write_b = 1'b1; if1.write_register_b = 3'd5; if1.write_data_b = 4'hC;
    #1;
    n_cmp++; if (if0.read_data[3:0] !== 4'hC) begin n_fail++; $display("FAIL dual_bypass: got %h want c", if0.read_data[3:0]); end
    n_cmp++; if (if1.read_data[3:0] !== 4'h0) begin n_fail++; $display("FAIL dual_nobypass_during: got %h want 0", if1.read_data[3:0]); end
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_data[3:0] !== 4'hC) begin n_fail++; $display("FAIL dual_stored: got %h want c", if0.read_data[3:0]); end
    n_cmp++; if (if1.read_data[3:0] !== 4'hC) begin n_fail++; $display("FAIL dual_nobypass_stored: got %h want c", if1.read_data[3:0]); end
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    if0.read_register = {3'd0, 3'd0};
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd0; if0.write_data_a = 4'hF;
    if0.lock_valid = 1'b1; if0.lock_register = 3'd0;
    #1;
    n_cmp++; if (if0.read_data !== 8'h00) begin n_fail++; $display("FAIL zero_during_data: got %h want 00", if0.read_data); end
    n_cmp++; if (if0.read_busy !== 2'b00) begin n_fail++; $display("FAIL zero_during_busy: got %b want 00", if0.read_busy); end
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_data !== 8'h00) begin n_fail++; $display("FAIL zero_after_data: got %h want 00", if0.read_data); end
    n_cmp++; if (if0.read_busy !== 2'b00) begin n_fail++; $display("FAIL zero_after_busy: got %b want 00", if0.read_busy); end
  endtask

  task automatic test_scoreboard();
    // cycle 0: lock r2 on both instances
    @(negedge clock);
    if0.read_register = {3'd0, 3'd2}; if1.read_register = {3'd0, 3'd2};
    if0.lock_valid = 1'b1; if0.lock_register = 3'd2;
    if1.lock_valid = 1'b1; if1.lock_register = 3'd2;
    #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_c0_busy: got %b want 0", if0.read_busy[0]); end
    n_cmp++; if (if1.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_c0_busy_nb: got %b want 0", if1.read_busy[0]); end
    // cycle 1
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_c1_busy: got %b want 1", if0.read_busy[0]); end
    n_cmp++; if (if1.read_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_c1_busy_nb: got %b want 1", if1.read_busy[0]); end
    // cycle 2
    @(negedge clock); #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_c2_busy: got %b want 1", if0.read_busy[0]); end
    // cycle 3: port A writes r2=7
    @(negedge clock);
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd2; if0.write_data_a = 4'h7;
    if1.reg_write_a = 1'b1; if1.write_register_a = 3'd2; if1.write_data_a = 4'h7;
    #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_c3_busy: got %b want 0", if0.read_busy[0]); end
    n_cmp++; if (if0.read_data[3:0] !== 4'h7) begin n_fail++; $display("FAIL sb_c3_data: got %h want 7", if0.read_data[3:0]); end
    n_cmp++; if (if1.read_busy[0] !== 1'b1) begin n_fail++; $display("FAIL sb_c3_busy_nb: got %b want 1", if1.read_busy[0]); end
    n_cmp++; if (if1.read_data[3:0] !== 4'h0) begin n_fail++; $display("FAIL sb_c3_data_nb: got %h want 0", if1.read_data[3:0]); end
    // cycle 4
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_c4_busy: got %b want 0", if0.read_busy[0]); end
    n_cmp++; if (if0.read_data[3:0] !== 4'h7) begin n_fail++; $display("FAIL sb_c4_data: got %h want 7", if0.read_data[3:0]); end
    n_cmp++; if (if1.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL sb_c4_busy_nb: got %b want 0", if1.read_busy[0]); end
    n_cmp++; if (if1.read_data[3:0] !== 4'h7) begin n_fail++; $display("FAIL sb_c4_data_nb: got %h want 7", if1.read_data[3:0]); end
  endtask

  task automatic test_lock_write_same();
    @(negedge clock);
    if0.read_register = {3'd0, 3'd6};
    if0.lock_valid = 1'b1; if0.lock_register = 3'd6;
    if0.reg_write_a = 1'b1; if0.write_register_a = 3'd6; if0.write_data_a = 4'h9;
    #1;
    n_cmp++; if (if0.read_data[3:0] !== 4'h9) begin n_fail++; $display("FAIL lw_during_data: got %h want 9", if0.read_data[3:0]); end
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL lw_during_busy: got %b want 0", if0.read_busy[0]); end
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_data[3:0] !== 4'h9) begin n_fail++; $display("FAIL lw_after_data: got %h want 9", if0.read_data[3:0]); end
    n_cmp++; if (if0.read_busy[0] !== 1'b1) begin n_fail++; $display("FAIL lw_after_busy: got %b want 1", if0.read_busy[0]); end
    // a plain port-B write to the locked register then retires it
    @(negedge clock);
    if0.reg_write_b = 1'b1; if0.write_register_b = 3'd6; if0.write_data_b = 4'h4;
    #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL lw_retire_busy: got %b want 0", if0.read_busy[0]); end
    n_cmp++; if (if0.read_data[3:0] !== 4'h4) begin n_fail++; $display("FAIL lw_retire_data: got %h want 4", if0.read_data[3:0]); end
    @(negedge clock); idle_all(); #1;
    n_cmp++; if (if0.read_busy[0] !== 1'b0) begin n_fail++; $display("FAIL lw_retired_busy: got %b want 0", if0.read_busy[0]); end
  endtask

  task automatic test_port_scaling();
    int vec [4][4] = '{'{0, 5, 10, 15}, '{1, 2, 3, 4}, '{15, 14, 13, 12}, '{7, 9, 11, 6}};
    logic [7:0] exp;
    logic [7:0] got;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if2.reg_write_a = 1'b1; if2.write_register_a = 4'(2*k);     if2.write_data_a = 8'((2*k) * 17);
      if2.reg_write_b = 1'b1; if2.write_register_b = 4'(2*k + 1); if2.write_data_b = 8'((2*k + 1) * 17);
    end
    @(negedge clock); idle_all();
    for (int v = 0; v < 4; v++) begin
      @(negedge clock);
      for (int p = 0; p < 4; p++) if2.read_register[p*4 +: 4] = 4'(vec[v][p]);
      #1;
      for (int p = 0; p < 4; p++) begin
        exp = (vec[v][p] == 0) ? 8'h00 : 8'(vec[v][p] * 17);
        got = if2.read_data[p*8 +: 8];
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL scale_v%0d_p%0d: got %h want %h", v, p, got, exp); end
      end
      n_cmp++; if (if2.read_busy !== 4'b0000) begin n_fail++; $display("FAIL scale_busy_v%0d: got %b want 0000", v, if2.read_busy); end
    end
  endtask

  initial begin
    idle_all();
    if0.read_register = '0; if1.read_register = '0; if2.read_register = '0;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_lock_write_same();
    test_port_scaling();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
